sdram_port_arbiter: RTL and testbench

- Multi-client arbiter placed in front of the single-port sdram controller.
- Generalises the fixed two-way download/core address/data mux into NUM_CH requester channels.
- Supports round-robin or fixed-priority selection, an exclusive mode for channel 0 (ROM/VHD download), per-transaction acknowledge, and a completion timeout.
- Clients are the download path, CPU, video fetch and similar; all run in clk_sys.

---
 rtl/sdram_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// NUM_CH-way arbiter in front of the single-port sdram controller: one transaction
// in flight, round-robin or fixed priority, exclusive channel 0, completion timeout.
module sdram_port_arbiter #(
    parameter int NUM_CH    = 3,
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 8,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     excl,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_din,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [DATA_W-1:0]        ch_dout,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_din,
    output logic                     mem_we,
    output logic                     mem_rd,
    input  logic                     mem_ready,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_dout,
    output logic [2:0]               grant,
    output logic                     busy,
    output logic                     timeout_flag
);

    // Requester handshake: a channel holds ch_req/ch_we/ch_addr/ch_din until it sees
    // its one-cycle ch_ack; once granted the transaction always completes, and a
    // request still high in the cycle after ch_ack is arbitrated as a new one.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state;
    logic [2:0]          rr_ptr;
    logic                we_q;
    logic [15:0]         wait_cnt;

    logic [NUM_CH-1:0]   eligible;
    logic [2:0]          winner;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_din;
    logic                win_we;
    logic [NUM_CH-1:0]   ack_vec;
    logic [2:0]          next_ptr;
    logic                done_now;

    assign eligible = excl ? (ch_req & {{(NUM_CH-1){1'b0}}, 1'b1}) : ch_req;
    assign next_ptr = (grant == 3'(NUM_CH - 1)) ? 3'd0 : grant + 3'd1;
    assign done_now = mem_ack || (wait_cnt == 16'(TIMEOUT));

    // Scanning offsets from the far end keeps the last hit, i.e. the closest one.
    always_comb begin
        winner   = 3'd0;
        win_addr = '0;
        win_din  = '0;
        win_we   = 1'b0;
        ack_vec  = '0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (eligible[j] && ((PRIO_MODE == 1) ? (j == off)
                                    : (j == (int'(rr_ptr) + off) % NUM_CH))) begin
                    winner = 3'(j);
                end
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (winner == 3'(j)) begin
                win_addr = ch_addr[j*ADDR_W +: ADDR_W];
                win_din  = ch_din[j*DATA_W +: DATA_W];
                win_we   = ch_we[j];
            end
            ack_vec[j] = (grant == 3'(j));
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= 3'd0;
            we_q         <= 1'b0;
            wait_cnt     <= 16'd0;
            ch_ack       <= '0;
            ch_dout      <= '0;
            mem_addr     <= '0;
            mem_din      <= '0;
            mem_we       <= 1'b0;
            mem_rd       <= 1'b0;
            grant        <= 3'd0;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            mem_rd <= 1'b0;
            ch_ack <= '0;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        mem_addr <= win_addr;
                        mem_din  <= win_din;
                        we_q     <= win_we;
                        grant    <= winner;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_we   <= we_q;
                        mem_rd   <= !we_q;
                        wait_cnt <= 16'd0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (done_now) begin
                        // A missing mem_ack completes a read with all-ones data.
                        if (!we_q) begin
                            ch_dout <= mem_ack ? mem_dout : '1;
                        end
                        if (!mem_ack) begin
                            timeout_flag <= 1'b1;
                        end
                        ch_ack <= ack_vec;
                        rr_ptr <= next_ptr;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a transaction table plus hand-written
// sequences for exclusive mode, reset during WAIT and round-robin vs fixed priority.
module tb_sdram_port_arbiter;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 23;
    localparam int DATA_W = 8;
    localparam int TMO    = 8;

    logic                     clk_sys = 1'b0;
    logic                     reset_n;
    logic                     excl;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_din;
    logic                     mem_ready;
    logic                     mem_ack;
    logic [DATA_W-1:0]        mem_dout;

    logic [NUM_CH-1:0]        ch_ack,   fp_ch_ack;
    logic [DATA_W-1:0]        ch_dout,  fp_ch_dout;
    logic [ADDR_W-1:0]        mem_addr, fp_mem_addr;
    logic [DATA_W-1:0]        mem_din,  fp_mem_din;
    logic                     mem_we,   fp_mem_we;
    logic                     mem_rd,   fp_mem_rd;
    logic [2:0]               grant,    fp_grant;
    logic                     busy,     fp_busy;
    logic                     timeout_flag, fp_timeout_flag;

    int n_vec  = 0;
    int n_miss = 0;

    // memory responder controls
    bit          ack_en    = 1'b1;
    int          ack_delay = 2;
    logic [7:0]  rdata_val = 8'h00;

    typedef struct {
        int         ch;
        logic       we;
        logic [22:0] addr;
        logic [7:0] din;
        int         ready_dly;
        int         ack_dly;
        logic [7:0] rdata;
        logic [7:0] exp_dout;
        int         exp_lat;
        logic       exp_tflag;
    } vec_t;

    vec_t vecs[6];
    int   exp_rr[6] = '{0, 1, 2, 0, 1, 2};

    always #5 clk_sys = ~clk_sys;

    sdram_port_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(0), .TIMEOUT(TMO)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .excl(excl),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_din(ch_din),
        .ch_ack(ch_ack), .ch_dout(ch_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_ready(mem_ready), .mem_ack(mem_ack), .mem_dout(mem_dout),
        .grant(grant), .busy(busy), .timeout_flag(timeout_flag)
    );

    sdram_port_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(1), .TIMEOUT(TMO)
    ) dut_fp (
        .clk_sys(clk_sys), .reset_n(reset_n), .excl(excl),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_din(ch_din),
        .ch_ack(fp_ch_ack), .ch_dout(fp_ch_dout),
        .mem_addr(fp_mem_addr), .mem_din(fp_mem_din), .mem_we(fp_mem_we), .mem_rd(fp_mem_rd),
        .mem_ready(mem_ready), .mem_ack(mem_ack), .mem_dout(mem_dout),
        .grant(fp_grant), .busy(fp_busy), .timeout_flag(fp_timeout_flag)
    );

    // acknowledges a strobe ack_delay edges after it becomes visible
    always begin
        @(posedge clk_sys);
        #1;
        if ((mem_rd || mem_we) && ack_en) begin
            repeat (ack_delay - 1) begin
                @(posedge clk_sys);
                #1;
            end
            mem_ack  = 1'b1;
            mem_dout = rdata_val;
            @(posedge clk_sys);
            #1;
            mem_ack  = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ch_ack"},   ch_ack, 0);
        check({tag, "_ch_dout"},  ch_dout, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_din"},  mem_din, 0);
        check({tag, "_strobes"},  {mem_we, mem_rd}, 0);
        check({tag, "_grant"},    grant, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_tflag"},    timeout_flag, 0);
    endtask

    task automatic run_txn(input vec_t v);
        bit granted = 1'b0;
        bit done    = 1'b0;
        int t = 0, gt = 0, st = 0, nstrobe = 0;
        ack_en    = (v.ack_dly != 0);
        ack_delay = v.ack_dly;
        rdata_val = v.rdata;
        mem_ready = (v.ready_dly == 0);
        ch_we[v.ch] = v.we;
        ch_addr[v.ch*ADDR_W +: ADDR_W] = v.addr;
        ch_din[v.ch*DATA_W +: DATA_W]  = v.din;
        ch_req[v.ch] = 1'b1;
        while (!done && t < 100) begin
            tick();
            t++;
            if (!granted && busy) begin
                granted = 1'b1;
                gt = t;
                ch_req[v.ch] = 1'b0;
                check("grant", grant, v.ch);
                check("mem_addr", mem_addr, v.addr);
                if (v.we) check("mem_din", mem_din, v.din);
            end
            if (granted && !mem_ready && (t - gt) >= v.ready_dly) mem_ready = 1'b1;
            if (mem_rd || mem_we) begin
                nstrobe++;
                st = t;
                check("strobe_kind", {mem_we, mem_rd}, v.we ? 2'b10 : 2'b01);
                check("strobe_time", t - gt, v.ready_dly + 1);
            end
            if (ch_ack != 0) begin
                done = 1'b1;
                check("ch_ack", ch_ack, 1 << v.ch);
                check("ch_dout", ch_dout, v.exp_dout);
                check("ack_latency", t - st, v.exp_lat);
                check("timeout_flag", timeout_flag, v.exp_tflag);
                check("busy_at_ack", busy, 0);
            end
        end
        check("txn_done", done, 1);
        check("one_strobe", nstrobe, 1);
        tick();
        check("ack_one_cycle", ch_ack, 0);
        check("idle_after", busy, 0);
        mem_ready = 1'b1;
    endtask

    initial begin
        bit   done;
        bit   saw_ack;
        int   ng, nack0;
        logic prev_busy;

        reset_n = 1'b0; excl = 1'b0; ch_req = '0; ch_we = '0; ch_addr = '0; ch_din = '0;
        mem_ready = 1'b1; mem_ack = 1'b0; mem_dout = '0;

        //                ch we    addr          din    rdy ack rdata  dout   lat tflag
        vecs[0] = '{1, 1'b0, 23'h001234, 8'h00, 0,  3, 8'h5A, 8'h5A, 3, 1'b0};
        vecs[1] = '{2, 1'b1, 23'h7FFFFF, 8'h3C, 0,  1, 8'h99, 8'h5A, 1, 1'b0};
        vecs[2] = '{0, 1'b0, 23'h000000, 8'h00, 10, 2, 8'hC3, 8'hC3, 2, 1'b0};
        vecs[3] = '{2, 1'b0, 23'h400001, 8'h00, 0,  5, 8'h00, 8'h00, 5, 1'b0};
        vecs[4] = '{1, 1'b0, 23'h0ABCDE, 8'h00, 0,  0, 8'h00, 8'hFF, 9, 1'b1};
        vecs[5] = '{0, 1'b1, 23'h155555, 8'hE7, 0,  2, 8'h11, 8'hFF, 2, 1'b1};

        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // exclusive: ch0 streams four writes while ch1/ch2 wait, then ch1 wins
        excl = 1'b1; ack_en = 1'b1; ack_delay = 2; rdata_val = 8'h42; mem_ready = 1'b1;
        ch_we = 3'b001;
        ch_addr = '0; ch_din = '0;
        ch_addr[1*ADDR_W +: ADDR_W] = 23'h000111;
        ch_addr[2*ADDR_W +: ADDR_W] = 23'h000222;
        ch_din[0 +: DATA_W] = 8'hA0;
        ch_req = 3'b111;
        ng = 0; nack0 = 0; done = 1'b0; prev_busy = busy;
        for (int t = 0; t < 200 && !done; t++) begin
            tick();
            if (busy && !prev_busy) begin
                if (ng < 4) begin
                    check("excl_grant", grant, 0);
                    check("excl_addr", mem_addr, ng);
                    check("excl_din", mem_din, 8'hA0 + ng);
                end else begin
                    check("post_excl_grant", grant, 1);
                    check("post_excl_addr", mem_addr, 23'h000111);
                    ch_req = '0;
                end
                ng++;
            end
            if ((mem_we || mem_rd) && ng <= 4) check("excl_we_strobe", {mem_we, mem_rd}, 2'b10);
            if (ch_ack != 0) begin
                if (ng <= 4) begin
                    check("excl_ack", ch_ack, 3'b001);
                    nack0++;
                    if (nack0 < 4) begin
                        ch_addr[0 +: ADDR_W] = 23'(nack0);
                        ch_din[0 +: DATA_W]  = 8'hA0 + 8'(nack0);
                    end else begin
                        ch_req[0] = 1'b0;
                        excl = 1'b0;
                    end
                end else begin
                    check("post_excl_ack", ch_ack, 3'b010);
                    check("post_excl_dout", ch_dout, 8'h42);
                    done = 1'b1;
                end
            end
            prev_busy = busy;
        end
        check("excl_done", done, 1);
        repeat (2) tick();
        check("excl_idle", busy, 0);
        check("tflag_sticky", timeout_flag, 1);

        // reset while waiting for mem_ack, then a late ack
        ack_en = 1'b0;
        ch_we[2] = 1'b0;
        ch_addr[2*ADDR_W +: ADDR_W] = 23'h2AAAAA;
        ch_req[2] = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            tick();
            if (busy) ch_req[2] = 1'b0;
            if (mem_rd) done = 1'b1;
        end
        check("rst_strobe_seen", done, 1);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_all_zero("midwait_reset");
        mem_dout = 8'h77;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        saw_ack = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (ch_ack != 0 || busy) saw_ack = 1'b1;
            tick();
        end
        check("no_ack_after_reset", saw_ack, 0);
        check("rst_dout", ch_dout, 0);
        check("rst_tflag", timeout_flag, 0);

        // round-robin vs fixed priority, all channels requesting
        ack_en = 1'b1; ack_delay = 2; mem_ready = 1'b1; ch_we = '0;
        ch_req = 3'b111;
        ng = 0; prev_busy = busy;
        for (int t = 0; t < 300 && ng < 6; t++) begin
            tick();
            if (busy && !prev_busy) begin
                check("rr_grant", grant, exp_rr[ng]);
                check("fp_grant", fp_grant, 0);
                ng++;
                if (ng == 6) ch_req = '0;
            end
            prev_busy = busy;
        end
        check("rr_count", ng, 6);
        done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            tick();
            if (!busy && !fp_busy) done = 1'b1;
        end
        check("rr_drain", done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
